// File: rtl/cr_osf_ob_sink.sv
// cr_osf_ob_sink
//   Receive-side endpoint for the output stream-formatter egress bus.
//   Accepts beats from the formatter, passes them unchanged through a
//   2-entry elastic buffer to the downstream consumer, and produces
//   byte/frame statistics strobes, a per-frame byte length, strobe and
//   oversize error pulses, and a frame-boundary halt.
//
// Ports (bus structs flattened to <bus>_<field>)
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_in_*             : upstream beat (tvalid, tlast, tid, tstrb, tuser, tdata)
//   rx_out_tready       : ready to upstream (depends on flops and sink_halt only)
//   dn_out_*            : buffered beat to the downstream consumer
//   dn_in_tready        : downstream ready
//   sink_halt           : stop accepting at the next frame boundary
//   ob_bytes_cnt_stb/amt: per-accepted-beat pulse and tstrb popcount
//   ob_frame_cnt_stb    : per-accepted-tlast-beat pulse
//   frame_len/_vld      : byte total of the last completed frame + update pulse
//   err_strb            : malformed tstrb pulse
//   err_oversize        : frame total above MAX_FRAME_BYTES pulse
//   sink_idle           : IDLE or HALTED with the buffer empty
`timescale 1ns/1ps
module cr_osf_ob_sink #(
    parameter logic [23:0] MAX_FRAME_BYTES = 24'd65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in_tvalid,
    input  logic        rx_in_tlast,
    input  logic [7:0]  rx_in_tid,
    input  logic [7:0]  rx_in_tstrb,
    input  logic [7:0]  rx_in_tuser,
    input  logic [63:0] rx_in_tdata,
    output logic        rx_out_tready,
    output logic        dn_out_tvalid,
    output logic        dn_out_tlast,
    output logic [7:0]  dn_out_tid,
    output logic [7:0]  dn_out_tstrb,
    output logic [7:0]  dn_out_tuser,
    output logic [63:0] dn_out_tdata,
    input  logic        dn_in_tready,
    input  logic        sink_halt,
    output logic        ob_bytes_cnt_stb,
    output logic [3:0]  ob_bytes_cnt_amt,
    output logic        ob_frame_cnt_stb,
    output logic [23:0] frame_len,
    output logic        frame_len_vld,
    output logic        err_strb,
    output logic        err_oversize,
    output logic        sink_idle
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam int unsigned PW = 1 + 8 + 8 + 8 + 64;

    state_t        state;
    logic          run;        // holds tready low for the first cycle after reset
    logic [PW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;
    logic [23:0]   len_acc;

    logic          acc;
    logic          pop;
    logic [3:0]    strb_cnt;
    logic [24:0]   sum_wide;
    logic [23:0]   sum;
    logic          strb_bad;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    always_comb begin
        rx_out_tready = run && (occ != 2'd2) && (state != HALTED)
                        && !((state == IDLE) && sink_halt);
        acc       = rx_in_tvalid && rx_out_tready;
        pop       = dn_out_tvalid && dn_in_tready;
        strb_cnt  = popcnt8(rx_in_tstrb);
        sum_wide  = {1'b0, len_acc} + {21'b0, strb_cnt};
        sum       = sum_wide[24] ? '1 : sum_wide[23:0];
        // last beat may be partial but must be a low-aligned thermometer code
        strb_bad  = rx_in_tlast ? ((rx_in_tstrb & (rx_in_tstrb + 8'd1)) != 8'd0)
                                : (rx_in_tstrb != 8'hFF);
        sink_idle = ((state == IDLE) || (state == HALTED)) && (occ == 2'd0);
    end

    assign dn_out_tvalid = (occ != 2'd0);
    assign {dn_out_tlast, dn_out_tid, dn_out_tstrb, dn_out_tuser, dn_out_tdata} = mem[rd_ptr];

    // Elastic buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (acc) begin
                mem[wr_ptr] <= {rx_in_tlast, rx_in_tid, rx_in_tstrb, rx_in_tuser, rx_in_tdata};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({acc, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Frame state, length accumulation and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            run              <= 1'b0;
            len_acc          <= '0;
            frame_len        <= '0;
            frame_len_vld    <= 1'b0;
            ob_bytes_cnt_stb <= 1'b0;
            ob_bytes_cnt_amt <= '0;
            ob_frame_cnt_stb <= 1'b0;
            err_strb         <= 1'b0;
            err_oversize     <= 1'b0;
        end else begin
            run              <= 1'b1;
            ob_bytes_cnt_stb <= acc;
            ob_bytes_cnt_amt <= acc ? strb_cnt : 4'd0;
            ob_frame_cnt_stb <= acc && rx_in_tlast;
            frame_len_vld    <= acc && rx_in_tlast;
            err_strb         <= acc && strb_bad;
            err_oversize     <= acc && rx_in_tlast && (sum > MAX_FRAME_BYTES);

            if (acc) begin
                if (rx_in_tlast) begin
                    frame_len <= sum;
                    len_acc   <= '0;
                end else begin
                    len_acc   <= sum;
                end
            end

            case (state)
                IDLE: begin
                    if (acc && !rx_in_tlast)  state <= IN_FRAME;
                    else if (!acc && sink_halt) state <= HALTED;
                end
                IN_FRAME: begin
                    if (acc && rx_in_tlast) state <= sink_halt ? HALTED : IDLE;
                end
                HALTED: begin
                    if (!sink_halt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_osf_ob_sink.sv
`timescale 1ns/1ps
module tb_cr_osf_ob_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_tvalid, rx_tlast;
    logic [7:0]  rx_tid, rx_tstrb, rx_tuser;
    logic [63:0] rx_tdata;
    logic        rx_tready;
    logic        dn_tvalid, dn_tlast;
    logic [7:0]  dn_tid, dn_tstrb, dn_tuser;
    logic [63:0] dn_tdata;
    logic        dn_rdy;
    logic        sink_halt;
    logic        bytes_stb;
    logic [3:0]  bytes_amt;
    logic        frame_stb;
    logic [23:0] frame_len;
    logic        frame_len_vld;
    logic        err_strb, err_oversize, sink_idle;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cr_osf_ob_sink #(.MAX_FRAME_BYTES(24'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_in_tvalid(rx_tvalid), .rx_in_tlast(rx_tlast), .rx_in_tid(rx_tid),
        .rx_in_tstrb(rx_tstrb), .rx_in_tuser(rx_tuser), .rx_in_tdata(rx_tdata),
        .rx_out_tready(rx_tready),
        .dn_out_tvalid(dn_tvalid), .dn_out_tlast(dn_tlast), .dn_out_tid(dn_tid),
        .dn_out_tstrb(dn_tstrb), .dn_out_tuser(dn_tuser), .dn_out_tdata(dn_tdata),
        .dn_in_tready(dn_rdy), .sink_halt(sink_halt),
        .ob_bytes_cnt_stb(bytes_stb), .ob_bytes_cnt_amt(bytes_amt),
        .ob_frame_cnt_stb(frame_stb), .frame_len(frame_len), .frame_len_vld(frame_len_vld),
        .err_strb(err_strb), .err_oversize(err_oversize), .sink_idle(sink_idle)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic last, input logic [7:0] strb, input logic [63:0] data);
        rx_tvalid = 1'b1;
        rx_tlast  = last;
        rx_tstrb  = strb;
        rx_tdata  = data;
        rx_tid    = data[7:0];
        rx_tuser  = data[15:8];
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sink_halt = 1'b0; dn_rdy = 1'b1;
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tstrb = '0; rx_tdata = '0; rx_tid = '0; rx_tuser = '0;
        repeat (3) tick;
        n_checks++; if (rx_tready !== 1'b0) $display("FAIL rst_tready: got %0h want 0", rx_tready); else n_pass++;
        n_checks++; if (dn_tvalid !== 1'b0) $display("FAIL rst_dn_valid: got %0h want 0", dn_tvalid); else n_pass++;
        n_checks++; if (dn_tdata !== 64'h0) $display("FAIL rst_dn_data: got %0h want 0", dn_tdata); else n_pass++;
        n_checks++; if (frame_len !== 24'h0) $display("FAIL rst_frame_len: got %0h want 0", frame_len); else n_pass++;
        n_checks++; if (bytes_stb !== 1'b0) $display("FAIL rst_bytes_stb: got %0h want 0", bytes_stb); else n_pass++;
        n_checks++; if (sink_idle !== 1'b1) $display("FAIL rst_sink_idle: got %0h want 1", sink_idle); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (rx_tready !== 1'b0) $display("FAIL rel_tready_early: got %0h want 0", rx_tready); else n_pass++;
        tick;
        n_checks++; if (rx_tready !== 1'b1) $display("FAIL rel_tready: got %0h want 1", rx_tready); else n_pass++;
    endtask

    task automatic test_three_beat;
        present(1'b0, 8'hFF, 64'hA1A1_0000_0000_0101);
        tick;
        n_checks++; if (bytes_stb !== 1'b1 || bytes_amt !== 4'd8) $display("FAIL tb1_amt: got %0h/%0d want 1/8", bytes_stb, bytes_amt); else n_pass++;
        n_checks++; if (frame_stb !== 1'b0) $display("FAIL tb1_frame_stb: got %0h want 0", frame_stb); else n_pass++;
        n_checks++; if (dn_tvalid !== 1'b1 || dn_tdata !== 64'hA1A1_0000_0000_0101) $display("FAIL tb1_dn: got %0h/%0h want 1/a1a1000000000101", dn_tvalid, dn_tdata); else n_pass++;
        present(1'b0, 8'hFF, 64'hA2A2_0000_0000_0202);
        tick;
        n_checks++; if (bytes_amt !== 4'd8) $display("FAIL tb2_amt: got %0d want 8", bytes_amt); else n_pass++;
        n_checks++; if (dn_tdata !== 64'hA2A2_0000_0000_0202 || dn_tid !== 8'h02) $display("FAIL tb2_dn: got %0h/%0h want a2a2000000000202/2", dn_tdata, dn_tid); else n_pass++;
        present(1'b1, 8'h0F, 64'hA3A3_0000_0000_0303);
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (bytes_amt !== 4'd4) $display("FAIL tb3_amt: got %0d want 4", bytes_amt); else n_pass++;
        n_checks++; if (frame_stb !== 1'b1) $display("FAIL tb3_frame_stb: got %0h want 1", frame_stb); else n_pass++;
        n_checks++; if (frame_len_vld !== 1'b1 || frame_len !== 24'd20) $display("FAIL tb3_len: got %0h/%0d want 1/20", frame_len_vld, frame_len); else n_pass++;
        n_checks++; if (dn_tdata !== 64'hA3A3_0000_0000_0303 || dn_tlast !== 1'b1 || dn_tstrb !== 8'h0F) $display("FAIL tb3_dn: got %0h/%0h/%0h want a3a3000000000303/1/f", dn_tdata, dn_tlast, dn_tstrb); else n_pass++;
        n_checks++; if (err_oversize !== 1'b1 || err_strb !== 1'b0) $display("FAIL tb3_err: got ovs %0h strb %0h want 1/0", err_oversize, err_strb); else n_pass++;
        tick;
        n_checks++; if (frame_len_vld !== 1'b0 || frame_stb !== 1'b0 || dn_tvalid !== 1'b0) $display("FAIL tb_after: got vld %0h fstb %0h dnv %0h want 0/0/0", frame_len_vld, frame_stb, dn_tvalid); else n_pass++;
    endtask

    task automatic test_stall;
        int   idx, accepts, rcv;
        logic acc_now, pop_now;
        logic [63:0] pop_data;
        logic pop_last;
        dn_rdy = 1'b0; idx = 0; accepts = 0; rcv = 0;
        present(1'b0, 8'hFF, 64'hB0);
        for (int c = 0; c < 5; c++) begin
            acc_now = rx_tvalid & rx_tready;
            tick;
            if (acc_now) begin
                accepts++; idx++;
                present(idx == 3, 8'hFF, 64'hB0 + 64'(idx));
            end
        end
        n_checks++; if (accepts !== 2) $display("FAIL stall_accepts: got %0d want 2", accepts); else n_pass++;
        n_checks++; if (rx_tready !== 1'b0) $display("FAIL stall_tready: got %0h want 0", rx_tready); else n_pass++;
        n_checks++; if (dn_tvalid !== 1'b1 || dn_tdata !== 64'hB0) $display("FAIL stall_head: got %0h/%0h want 1/b0", dn_tvalid, dn_tdata); else n_pass++;
        dn_rdy = 1'b1;
        for (int c = 0; c < 20 && rcv < 4; c++) begin
            acc_now  = rx_tvalid & rx_tready;
            pop_now  = dn_tvalid & dn_rdy;
            pop_data = dn_tdata;
            pop_last = dn_tlast;
            tick;
            if (pop_now) begin
                n_checks++;
                if (pop_data !== 64'hB0 + 64'(rcv) || pop_last !== (rcv == 3))
                    $display("FAIL stall_order%0d: got %0h/%0h want %0h/%0h", rcv, pop_data, pop_last, 64'hB0 + 64'(rcv), (rcv == 3));
                else n_pass++;
                rcv++;
            end
            if (acc_now) begin
                idx++;
                if (idx < 4) present(idx == 3, 8'hFF, 64'hB0 + 64'(idx));
                else rx_tvalid = 1'b0;
            end
        end
        n_checks++; if (rcv !== 4) $display("FAIL stall_received: got %0d want 4", rcv); else n_pass++;
        rx_tvalid = 1'b0;
        tick;
    endtask

    task automatic test_halt;
        present(1'b0, 8'hFF, 64'hC0);
        tick;
        present(1'b0, 8'hFF, 64'hC1);
        sink_halt = 1'b1;
        tick;
        present(1'b0, 8'hFF, 64'hC2);
        n_checks++; if (rx_tready !== 1'b1) $display("FAIL halt_beat3_rdy: got %0h want 1", rx_tready); else n_pass++;
        tick;
        present(1'b1, 8'hFF, 64'hC3);
        n_checks++; if (rx_tready !== 1'b1) $display("FAIL halt_beat4_rdy: got %0h want 1", rx_tready); else n_pass++;
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (rx_tready !== 1'b0) $display("FAIL halt_after_last: got %0h want 0", rx_tready); else n_pass++;
        n_checks++; if (frame_len_vld !== 1'b1 || frame_len !== 24'd32) $display("FAIL halt_len: got %0h/%0d want 1/32", frame_len_vld, frame_len); else n_pass++;
        tick;
        n_checks++; if (sink_idle !== 1'b1 || rx_tready !== 1'b0) $display("FAIL halt_idle: got idle %0h rdy %0h want 1/0", sink_idle, rx_tready); else n_pass++;
        tick;
        sink_halt = 1'b0;
        #1;
        n_checks++; if (rx_tready !== 1'b0) $display("FAIL halt_still: got %0h want 0", rx_tready); else n_pass++;
        tick;
        n_checks++; if (rx_tready !== 1'b1) $display("FAIL halt_resume: got %0h want 1", rx_tready); else n_pass++;
        present(1'b1, 8'h03, 64'hD0D0);
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (frame_len_vld !== 1'b1 || frame_len !== 24'd2 || err_strb !== 1'b0) $display("FAIL halt_resume_len: got %0h/%0d/%0h want 1/2/0", frame_len_vld, frame_len, err_strb); else n_pass++;
        n_checks++; if (dn_tdata !== 64'hD0D0) $display("FAIL halt_resume_dn: got %0h want d0d0", dn_tdata); else n_pass++;
        tick;
    endtask

    task automatic test_strb_err;
        present(1'b0, 8'h7F, 64'hE0);
        tick;
        n_checks++; if (err_strb !== 1'b1 || bytes_amt !== 4'd7) $display("FAIL strb_nonlast: got %0h/%0d want 1/7", err_strb, bytes_amt); else n_pass++;
        present(1'b1, 8'h05, 64'hE1);
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (err_strb !== 1'b1) $display("FAIL strb_last: got %0h want 1", err_strb); else n_pass++;
        n_checks++; if (frame_len !== 24'd9 || frame_len_vld !== 1'b1 || err_oversize !== 1'b0) $display("FAIL strb_len: got %0d/%0h/%0h want 9/1/0", frame_len, frame_len_vld, err_oversize); else n_pass++;
        tick;
        n_checks++; if (err_strb !== 1'b0) $display("FAIL strb_clear: got %0h want 0", err_strb); else n_pass++;
    endtask

    task automatic test_oversize;
        present(1'b0, 8'hFF, 64'hF0);
        tick;
        present(1'b0, 8'hFF, 64'hF1);
        n_checks++; if (err_oversize !== 1'b0) $display("FAIL ovs_early: got %0h want 0", err_oversize); else n_pass++;
        tick;
        present(1'b1, 8'hFF, 64'hF2);
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (err_oversize !== 1'b1 || frame_len_vld !== 1'b1) $display("FAIL ovs_pulse: got %0h/%0h want 1/1", err_oversize, frame_len_vld); else n_pass++;
        n_checks++; if (frame_len !== 24'd24) $display("FAIL ovs_len: got %0d want 24", frame_len); else n_pass++;
        tick;
        n_checks++; if (err_oversize !== 1'b0) $display("FAIL ovs_clear: got %0h want 0", err_oversize); else n_pass++;
    endtask

    task automatic test_back_to_back;
        present(1'b1, 8'h01, 64'h11);
        tick;
        present(1'b1, 8'h00, 64'h12);
        n_checks++; if (frame_len_vld !== 1'b1 || frame_len !== 24'd1) $display("FAIL b2b_1: got %0h/%0d want 1/1", frame_len_vld, frame_len); else n_pass++;
        tick;
        present(1'b1, 8'hFF, 64'h13);
        n_checks++; if (frame_len_vld !== 1'b1 || frame_len !== 24'd0 || err_strb !== 1'b0) $display("FAIL b2b_2: got %0h/%0d/%0h want 1/0/0", frame_len_vld, frame_len, err_strb); else n_pass++;
        n_checks++; if (bytes_stb !== 1'b1 || bytes_amt !== 4'd0) $display("FAIL b2b_2_amt: got %0h/%0d want 1/0", bytes_stb, bytes_amt); else n_pass++;
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (frame_len_vld !== 1'b1 || frame_len !== 24'd8 || err_strb !== 1'b0) $display("FAIL b2b_3: got %0h/%0d/%0h want 1/8/0", frame_len_vld, frame_len, err_strb); else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid;
        present(1'b0, 8'hFF, 64'h21);
        tick;
        present(1'b0, 8'hFF, 64'h22);
        tick;
        rx_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (frame_len !== 24'd0 || frame_len_vld !== 1'b0) $display("FAIL rmid_len: got %0d/%0h want 0/0", frame_len, frame_len_vld); else n_pass++;
        n_checks++; if (rx_tready !== 1'b0 || dn_tvalid !== 1'b0) $display("FAIL rmid_bus: got %0h/%0h want 0/0", rx_tready, dn_tvalid); else n_pass++;
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++; if (frame_len_vld !== 1'b0 || rx_tready !== 1'b1) $display("FAIL rmid_release: got %0h/%0h want 0/1", frame_len_vld, rx_tready); else n_pass++;
        present(1'b1, 8'h01, 64'h23);
        tick;
        rx_tvalid = 1'b0;
        n_checks++; if (frame_len !== 24'd1 || frame_len_vld !== 1'b1) $display("FAIL rmid_frame: got %0d/%0h want 1/1", frame_len, frame_len_vld); else n_pass++;
        tick;
        n_checks++; if (frame_len_vld !== 1'b0) $display("FAIL rmid_stale: got %0h want 0", frame_len_vld); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_three_beat;
        test_stall;
        test_halt;
        test_strb_err;
        test_oversize;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
